// File: rtl/slc_pkg.sv
// Shared SLC request-channel types: flit layout, link FSM states and the
// opcode that marks a link-credit-return flit.
package slc_pkg;

    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgtid;
        logic [6:0]  srcid;
        logic [7:0]  txnid;
        logic [6:0]  opcode;
        logic [31:0] addr;
    } reqflit_t;

    typedef enum logic [1:0] {
        STOP,
        ACTIVATE,
        RUN,
        DEACTIVATE
    } link_state_e;

    localparam logic [6:0] REQ_LCRD_RETURN = 7'h00;

    function automatic logic is_lcrd_return(input reqflit_t f);
        return f.opcode == REQ_LCRD_RETURN;
    endfunction

endpackage

// File: rtl/slc_flit_fifo.sv
// Synchronous FIFO with a registered head: head_data/head_valid are flops
// so the consumer sees a stable, glitch-free flit.
module slc_flit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_inc, rd_ptr_inc;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             head_valid_reg;
    logic             head_load;
    logic             do_push, do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_inc = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    assign rd_ptr_inc = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    assign count_next = count_reg + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Head reloads from the next stored entry on a pop, or straight from the
    // input when the pushed flit becomes the only entry.
    always_comb begin
        head_load = 1'b0;
        head_next = head_reg;
        if (do_pop && (count_reg > CW'(1))) begin
            head_load = 1'b1;
            head_next = mem[rd_ptr_inc];
        end else if (do_push && (empty || (do_pop && (count_reg == CW'(1))))) begin
            head_load = 1'b1;
            head_next = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_reg       <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_inc;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            if (head_load) begin
                head_reg <= head_next;
            end
            count_reg      <= count_next;
            head_valid_reg <= (count_next != '0);
        end
    end

    assign head_data  = head_reg;
    assign head_valid = head_valid_reg;
    assign count      = count_reg;

    no_write_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) !(push && full && !pop)
    );

endmodule

// File: rtl/slc_rxreq.sv
// SLC request-channel link receiver: link activation FSM, L-credit issue and
// accounting, credit-return filtering, and buffering toward the POCQ.
module slc_rxreq
    import slc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     rxlinkactivereq,
    output logic     rxlinkactiveack,
    input  logic     rxreqflitv,
    input  reqflit_t rxreqflit,
    output logic     rxreqlcrdv,
    output logic     pout_valid,
    input  logic     pout_ready,
    output reqflit_t pout_data,
    output logic     proto_err
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          FW      = $bits(reqflit_t);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    link_state_e   state_reg, state_next;
    logic [CW-1:0] crd_out_reg, crd_out_next;
    logic          ack_reg, ack_next;
    logic          lcrdv_reg, crd_issue;
    logic          err_reg;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, head_valid;
    logic [FW-1:0] head_data;

    logic          link_up, flit_ok, flit_err, push, pop, slot_free;

    assign link_up   = (state_reg == RUN) || (state_reg == DEACTIVATE);
    // A flit must consume a credit we granted; anything else is dropped and flagged.
    assign flit_ok   = rxreqflitv && link_up && (crd_out_reg != '0);
    assign flit_err  = rxreqflitv && !flit_ok;
    assign push      = flit_ok && !is_lcrd_return(rxreqflit);
    assign pop       = pout_ready && !fifo_empty;
    assign slot_free = ({1'b0, fifo_count} + {1'b0, crd_out_reg}) < DEPTH_W;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= STOP;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            STOP:       if (rxlinkactivereq) state_next = ACTIVATE;
            ACTIVATE:   state_next = RUN;
            RUN:        if (!rxlinkactivereq) state_next = DEACTIVATE;
            DEACTIVATE: if (crd_out_reg == '0) state_next = STOP;
            default:    state_next = STOP;
        endcase
    end

    // Ack is decoded from the next state so it leaves a flop aligned with the state.
    always_comb begin
        ack_next     = (state_next == RUN) || (state_next == DEACTIVATE);
        crd_issue    = (state_reg == RUN) && rxlinkactivereq && slot_free;
        crd_out_next = crd_out_reg + CW'(crd_issue) - CW'(flit_ok);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_reg     <= 1'b0;
            lcrdv_reg   <= 1'b0;
            crd_out_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            ack_reg     <= ack_next;
            lcrdv_reg   <= crd_issue;
            crd_out_reg <= crd_out_next;
            if (flit_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    slc_flit_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clock),
        .rst_n      (reset),
        .push       (push),
        .push_data  (rxreqflit),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign rxlinkactiveack = ack_reg;
    assign rxreqlcrdv      = lcrdv_reg;
    assign pout_valid      = head_valid;
    assign pout_data       = reqflit_t'(head_data);
    assign proto_err       = err_reg;

    credit_bound : assert property (
        @(posedge clock) disable iff (!reset)
        ({1'b0, fifo_count} + {1'b0, crd_out_reg}) <= DEPTH_W
    );

    full_means_no_credit : assert property (
        @(posedge clock) disable iff (!reset) !(fifo_full && (crd_out_reg != '0))
    );

endmodule

// File: tb/tb_slc_rxreq.sv
// Directed bench for slc_rxreq: stimulus pushes expected flits into a queue,
// an independent monitor pops and compares on every pout handshake.
module tb_slc_rxreq;
    import slc_pkg::*;

    localparam int DEPTH = 4;

    logic     clock = 1'b0;
    logic     reset = 1'b0;
    logic     rxlinkactivereq = 1'b0;
    logic     rxlinkactiveack;
    logic     rxreqflitv = 1'b0;
    reqflit_t rxreqflit = '0;
    logic     rxreqlcrdv;
    logic     pout_valid;
    logic     pout_ready = 1'b0;
    reqflit_t pout_data;
    logic     proto_err;

    int       checks = 0;
    int       failures = 0;
    int       pool = 0;
    int       lcrd_total = 0;
    int       base = 0;
    reqflit_t exp_q[$];
    reqflit_t mon_exp;

    always #5 clock = ~clock;

    slc_rxreq #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .rxlinkactivereq (rxlinkactivereq),
        .rxlinkactiveack (rxlinkactiveack),
        .rxreqflitv      (rxreqflitv),
        .rxreqflit       (rxreqflit),
        .rxreqlcrdv      (rxreqlcrdv),
        .pout_valid      (pout_valid),
        .pout_ready      (pout_ready),
        .pout_data       (pout_data),
        .proto_err       (proto_err)
    );

    // Upstream credit pool: every observed pulse is one usable credit.
    always @(negedge clock) begin
        if (rxreqlcrdv) begin
            pool++;
            lcrd_total++;
        end
    end

    // Scoreboard monitor: the handshake completes on the following rising edge.
    always @(negedge clock) begin
        if (reset && pout_valid && pout_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none", pout_data);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("pop txnid=%0h opcode=%0h", pout_data.txnid, pout_data.opcode);
                if (pout_data !== mon_exp) begin
                    failures++;
                    $display("FAIL pop_data actual=%0h required=%0h", pout_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic reqflit_t mk(input logic [6:0] op, input logic [7:0] id);
        reqflit_t f;
        f        = '0;
        f.qos    = 4'h3;
        f.tgtid  = 7'h22;
        f.srcid  = 7'h11;
        f.txnid  = id;
        f.opcode = op;
        f.addr   = {id, 24'hA5C300};
        return f;
    endfunction

    task automatic send(input reqflit_t f, input bit enq, input bit need_crd);
        int guard;
        guard = 0;
        if (need_crd) begin
            while (pool == 0 && guard < 50) begin
                tick();
                guard++;
            end
            if (pool == 0) begin
                checks++;
                failures++;
                $display("FAIL credit_wait actual=0 required=1");
                return;
            end
            pool--;
        end
        rxreqflitv = 1'b1;
        rxreqflit  = f;
        if (enq) exp_q.push_back(f);
        $display("send txnid=%0h opcode=%0h", f.txnid, f.opcode);
        tick();
        rxreqflitv = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_ack", rxlinkactiveack, 0);
        check("rst_lcrdv", rxreqlcrdv, 0);
        check("rst_valid", pout_valid, 0);
        check("rst_err", proto_err, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Activation: request raised in cycle 0.
        rxlinkactivereq = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("act_ack_c%0d", c), rxlinkactiveack, (c >= 2));
            check($sformatf("act_lcrdv_c%0d", c), rxreqlcrdv, (c >= 3 && c <= 6));
        end
        check("act_pool", pool, 4);

        // Fill with the consumer stalled, then release it.
        tick();
        for (int i = 0; i < 4; i++) send(mk(7'h04 + 7'(i), 8'h10 + 8'(i)), 1'b1, 1'b1);
        base = lcrd_total;
        repeat (4) begin
            @(negedge clock);
            check("hold_valid", pout_valid, 1);
            check("hold_data", pout_data, mk(7'h04, 8'h10));
        end
        tick();
        check("full_no_credit", lcrd_total - base, 0);
        pout_ready = 1'b1;
        drain();
        repeat (6) tick();
        check("recycle_credits", lcrd_total - base, 4);
        check("recycle_pool", pool, 4);

        // Credit-return flits consume credits but never reach the output.
        send(mk(REQ_LCRD_RETURN, 8'h20), 1'b0, 1'b1);
        send(mk(7'h05, 8'h21), 1'b1, 1'b1);
        send(mk(REQ_LCRD_RETURN, 8'h22), 1'b0, 1'b1);
        send(mk(7'h06, 8'h23), 1'b1, 1'b1);
        drain();
        repeat (6) tick();
        check("filter_pool", pool, 4);
        check("filter_idle", pout_valid, 0);

        // Deactivation with 3 credits left outstanding.
        base = lcrd_total;
        rxlinkactivereq = 1'b0;
        send(mk(7'h07, 8'h30), 1'b1, 1'b1);
        repeat (5) begin
            @(negedge clock);
            check("deact_ack", rxlinkactiveack, 1);
        end
        tick();
        check("deact_no_credit", lcrd_total - base, 0);
        drain();
        for (int i = 0; i < 3; i++) send(mk(REQ_LCRD_RETURN, 8'h31 + 8'(i)), 1'b0, 1'b1);
        tick();
        check("deact_stop_ack", rxlinkactiveack, 0);
        check("deact_pool", pool, 0);

        // Flit while the link is stopped.
        send(mk(7'h08, 8'h40), 1'b0, 1'b0);
        @(negedge clock);
        check("stop_err", proto_err, 1);
        check("stop_no_valid", pout_valid, 0);
        repeat (3) tick();
        check("stop_no_valid2", pout_valid, 0);

        // Reactivate; the error flag must survive.
        rxlinkactivereq = 1'b1;
        repeat (10) tick();
        check("react_pool", pool, 4);
        check("err_sticky", proto_err, 1);

        // Asynchronous reset with two flits buffered.
        pout_ready = 1'b0;
        send(mk(7'h09, 8'h50), 1'b1, 1'b1);
        send(mk(7'h0A, 8'h51), 1'b1, 1'b1);
        tick();
        check("pre_rst_valid", pout_valid, 1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("arst_ack", rxlinkactiveack, 0);
        check("arst_lcrdv", rxreqlcrdv, 0);
        check("arst_valid", pout_valid, 0);
        check("arst_err", proto_err, 0);
        exp_q.delete();
        pool = 0;
        rxlinkactivereq = 1'b0;
        tick();
        reset = 1'b1;
        base = lcrd_total;
        repeat (3) tick();
        check("post_rst_ack", rxlinkactiveack, 0);
        check("post_rst_valid", pout_valid, 0);
        check("post_rst_credit", lcrd_total - base, 0);

        // A fifth flit on only four credits.
        rxlinkactivereq = 1'b1;
        repeat (10) tick();
        check("fifth_pool", pool, 4);
        for (int i = 0; i < 4; i++) send(mk(7'h0B + 7'(i), 8'h60 + 8'(i)), 1'b1, 1'b1);
        check("fifth_pre_err", proto_err, 0);
        send(mk(7'h0F, 8'h64), 1'b0, 1'b0);
        @(negedge clock);
        check("fifth_err", proto_err, 1);
        pout_ready = 1'b1;
        drain();
        repeat (4) tick();
        check("fifth_idle", pout_valid, 0);
        check("fifth_err_sticky", proto_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
